// File: rtl/adder_chk_pkg.sv
// Shared types and constants for adder response checkers: FSM states,
// vector-count helper and the saturating error-counter step.
package adder_chk_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam int unsigned ERR_W_DEFAULT = 16;

  // Step applied to the error counter; it holds once it reaches all-ones.
  localparam int unsigned ERR_INC = 1;

  // Exhaustive vector count for a W-bit adder: every a, b and cin.
  function automatic int unsigned num_vec(input int unsigned w);
    return 32'd1 << (2 * w + 1);
  endfunction

endpackage

// File: rtl/adder_ref_model.sv
// Combinational golden W-bit adder: sum = a + b + cin at W+1 bits.
module adder_ref_model #(
  parameter int unsigned W = 4
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W:0]   sum
);

  assign sum = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};

endmodule

// File: rtl/adder_response_checker.sv
// Response checker for an exhaustively driven W-bit adder: golden compare,
// counting-order check, saturating error count and first-fail capture.
module adder_response_checker
  import adder_chk_pkg::*;
#(
  parameter int unsigned W     = 4,
  parameter int unsigned ERR_W = ERR_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             vld,
  input  logic [W-1:0]     a,
  input  logic [W-1:0]     b,
  input  logic             cin,
  input  logic [W-1:0]     s,
  input  logic             cout,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_cnt,
  output logic             seq_err,
  output logic [2*W+1:0]   vec_cnt,
  output logic             ff_valid,
  output logic [W-1:0]     ff_a,
  output logic [W-1:0]     ff_b,
  output logic             ff_cin,
  output logic [W:0]       ff_s
);

  localparam int unsigned IDX_W = 2 * W + 1;
  localparam int unsigned CNT_W = 2 * W + 2;
  localparam logic [CNT_W-1:0] NUM_VEC = CNT_W'(num_vec(W));

  state_e             state_q, state_d;
  logic               busy_q, busy_d, done_q, done_d, pass_q, pass_d;
  logic [ERR_W-1:0]   err_cnt_q, err_cnt_d;
  logic               seq_err_q, seq_err_d;
  logic [CNT_W-1:0]   vec_cnt_q, vec_cnt_d;
  logic [IDX_W-1:0]   exp_idx_q, exp_idx_d;
  logic               ff_valid_q, ff_valid_d, ff_cin_q, ff_cin_d;
  logic [W-1:0]       ff_a_q, ff_a_d, ff_b_q, ff_b_d;
  logic [W:0]         ff_s_q, ff_s_d;
  // Sample stage: the vector accepted at edge t is committed at edge t+1.
  logic               stg_vld_q, stg_vld_d, stg_cin_q, stg_cin_d;
  logic               stg_seq_bad_q, stg_seq_bad_d;
  logic [W-1:0]       stg_a_q, stg_a_d, stg_b_q, stg_b_d;
  logic [W:0]         stg_obs_q, stg_obs_d;

  logic               accept, arm, mismatch;
  logic [W:0]         exp_sum;

  adder_ref_model #(.W(W)) u_ref (
    .a   (stg_a_q),
    .b   (stg_b_q),
    .cin (stg_cin_q),
    .sum (exp_sum)
  );

  always_comb begin
    // NOTE: every variable gets a default first so no path can infer a latch.
    state_d       = state_q;
    err_cnt_d     = err_cnt_q;
    seq_err_d     = seq_err_q;
    vec_cnt_d     = vec_cnt_q;
    exp_idx_d     = exp_idx_q;
    ff_valid_d    = ff_valid_q;
    ff_a_d        = ff_a_q;
    ff_b_d        = ff_b_q;
    ff_cin_d      = ff_cin_q;
    ff_s_d        = ff_s_q;

    accept   = (state_q == RUN) && vld;
    arm      = start && ((state_q == IDLE) || (state_q == DONE));
    mismatch = stg_vld_q && (stg_obs_q != exp_sum);

    stg_vld_d     = accept;
    stg_a_d       = a;
    stg_b_d       = b;
    stg_cin_d     = cin;
    stg_obs_d     = {cout, s};
    stg_seq_bad_d = accept && ({cin, b, a} != exp_idx_q);

    if (mismatch) begin
      if (err_cnt_q != '1) err_cnt_d = err_cnt_q + ERR_W'(ERR_INC);
      if (!ff_valid_q) begin
        ff_valid_d = 1'b1;
        ff_a_d     = stg_a_q;
        ff_b_d     = stg_b_q;
        ff_cin_d   = stg_cin_q;
        ff_s_d     = stg_obs_q;
      end
    end
    if (stg_vld_q && stg_seq_bad_q) seq_err_d = 1'b1;

    if (accept) begin
      vec_cnt_d = vec_cnt_q + CNT_W'(1);
      exp_idx_d = exp_idx_q + IDX_W'(1);
    end

    unique case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (accept && (vec_cnt_d == NUM_VEC)) state_d = DRAIN;
      DRAIN:   state_d = DONE;
      DONE:    if (start) state_d = RUN;
      default: state_d = IDLE;
    endcase

    if (arm) begin
      err_cnt_d  = '0;
      seq_err_d  = 1'b0;
      vec_cnt_d  = '0;
      exp_idx_d  = '0;
      ff_valid_d = 1'b0;
      ff_a_d     = '0;
      ff_b_d     = '0;
      ff_cin_d   = 1'b0;
      ff_s_d     = '0;
      stg_vld_d  = 1'b0;
    end

    busy_d = (state_d == RUN) || (state_d == DRAIN);
    done_d = (state_q == DONE) && !arm;
    pass_d = done_d && (err_cnt_q == '0) && !seq_err_q;
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only.
    if (rst) begin
      state_q       <= IDLE;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      pass_q        <= 1'b0;
      err_cnt_q     <= '0;
      seq_err_q     <= 1'b0;
      vec_cnt_q     <= '0;
      exp_idx_q     <= '0;
      ff_valid_q    <= 1'b0;
      ff_a_q        <= '0;
      ff_b_q        <= '0;
      ff_cin_q      <= 1'b0;
      ff_s_q        <= '0;
      stg_vld_q     <= 1'b0;
      stg_a_q       <= '0;
      stg_b_q       <= '0;
      stg_cin_q     <= 1'b0;
      stg_obs_q     <= '0;
      stg_seq_bad_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      pass_q        <= pass_d;
      err_cnt_q     <= err_cnt_d;
      seq_err_q     <= seq_err_d;
      vec_cnt_q     <= vec_cnt_d;
      exp_idx_q     <= exp_idx_d;
      ff_valid_q    <= ff_valid_d;
      ff_a_q        <= ff_a_d;
      ff_b_q        <= ff_b_d;
      ff_cin_q      <= ff_cin_d;
      ff_s_q        <= ff_s_d;
      stg_vld_q     <= stg_vld_d;
      stg_a_q       <= stg_a_d;
      stg_b_q       <= stg_b_d;
      stg_cin_q     <= stg_cin_d;
      stg_obs_q     <= stg_obs_d;
      stg_seq_bad_q <= stg_seq_bad_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign pass     = pass_q;
  assign err_cnt  = err_cnt_q;
  assign seq_err  = seq_err_q;
  assign vec_cnt  = vec_cnt_q;
  assign ff_valid = ff_valid_q;
  assign ff_a     = ff_a_q;
  assign ff_b     = ff_b_q;
  assign ff_cin   = ff_cin_q;
  assign ff_s     = ff_s_q;

endmodule

// File: tb/tb_adder_response_checker.sv
// Scoreboard bench: each run pushes its expected final result; a monitor
// pops and compares whenever done rises.
module tb_adder_response_checker;

  localparam int W     = 4;
  localparam int ERR_W = 16;

  localparam int M_GOOD   = 0;
  localparam int M_FAULT1 = 1;
  localparam int M_STUCK  = 2;

  logic             clk, rst, start, vld, cin, cout;
  logic [W-1:0]     a, b, s;
  logic             busy, done, pass, seq_err, ff_valid, ff_cin;
  logic [ERR_W-1:0] err_cnt;
  logic [2*W+1:0]   vec_cnt;
  logic [W-1:0]     ff_a, ff_b;
  logic [W:0]       ff_s;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    string    name;
    int       err;
    bit       seq;
    bit       pass;
    int       vcnt;
    bit       ffv;
    int       fa;
    int       fb;
    int       fcin;
    int       fs;
  } exp_t;

  exp_t exp_q[$];

  adder_response_checker #(.W(W), .ERR_W(ERR_W)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .vld      (vld),
    .a        (a),
    .b        (b),
    .cin      (cin),
    .s        (s),
    .cout     (cout),
    .busy     (busy),
    .done     (done),
    .pass     (pass),
    .err_cnt  (err_cnt),
    .seq_err  (seq_err),
    .vec_cnt  (vec_cnt),
    .ff_valid (ff_valid),
    .ff_a     (ff_a),
    .ff_b     (ff_b),
    .ff_cin   (ff_cin),
    .ff_s     (ff_s)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: compare the DUT's final result against the scoreboard on done rise.
  initial begin
    logic done_prev;
    exp_t e;
    done_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (done === 1'b1 && done_prev !== 1'b1) begin
        if (exp_q.size() == 0) begin
          check("unexpected_done", 32'(done), 32'd0);
        end else begin
          e = exp_q.pop_front();
          check({e.name, ".err_cnt"},  32'(err_cnt),  e.err);
          check({e.name, ".seq_err"},  32'(seq_err),  32'(e.seq));
          check({e.name, ".pass"},     32'(pass),     32'(e.pass));
          check({e.name, ".vec_cnt"},  32'(vec_cnt),  e.vcnt);
          check({e.name, ".ff_valid"}, 32'(ff_valid), 32'(e.ffv));
          check({e.name, ".ff_a"},     32'(ff_a),     e.fa);
          check({e.name, ".ff_b"},     32'(ff_b),     e.fb);
          check({e.name, ".ff_cin"},   32'(ff_cin),   e.fcin);
          check({e.name, ".ff_s"},     32'(ff_s),     e.fs);
        end
      end
      done_prev = done;
    end
  end

  task automatic push_exp(input string nm, input int err, input bit seq, input bit pss,
                          input bit ffv, input int fa, input int fb, input int fcin, input int fs);
    exp_t e;
    e.name = nm; e.err = err; e.seq = seq; e.pass = pss; e.vcnt = 512;
    e.ffv = ffv; e.fa = fa; e.fb = fb; e.fcin = fcin; e.fs = fs;
    exp_q.push_back(e);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".busy"},     32'(busy),     32'd0);
    check({tag, ".done"},     32'(done),     32'd0);
    check({tag, ".pass"},     32'(pass),     32'd0);
    check({tag, ".err_cnt"},  32'(err_cnt),  32'd0);
    check({tag, ".seq_err"},  32'(seq_err),  32'd0);
    check({tag, ".vec_cnt"},  32'(vec_cnt),  32'd0);
    check({tag, ".ff_valid"}, 32'(ff_valid), 32'd0);
    check({tag, ".ff_a"},     32'(ff_a),     32'd0);
    check({tag, ".ff_b"},     32'(ff_b),     32'd0);
    check({tag, ".ff_cin"},   32'(ff_cin),   32'd0);
    check({tag, ".ff_s"},     32'(ff_s),     32'd0);
  endtask

  // Applies vector idx = {cin,b,a} from an adder that is correct except for the mode's fault.
  task automatic drive_vec(input logic [8:0] idx, input int mode);
    logic [4:0] sum;
    a    = idx[3:0];
    b    = idx[7:4];
    cin  = idx[8];
    sum  = {1'b0, idx[3:0]} + {1'b0, idx[7:4]} + {4'b0, idx[8]};
    s    = sum[3:0];
    cout = sum[4];
    if (mode == M_FAULT1 && idx == 9'h053) s = 4'h0;
    if (mode == M_STUCK) cout = 1'b0;
    vld = 1'b1;
  endtask

  task automatic run_vectors(input int mode, input int skip, input int n_acc, input bit gap);
    int idx;
    idx = 0;
    for (int k = 0; k < n_acc; k++) begin
      if (idx == skip) idx++;
      drive_vec(9'(idx), mode);
      idx++;
      @(posedge clk); #1;
      if (gap && k != n_acc - 1) begin
        vld = 1'b0;
        @(posedge clk); #1;
      end
    end
    vld = 1'b0;
  endtask

  task automatic pulse_start(input string tag);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check({tag, ".busy_after_start"}, 32'(busy), 32'd1);
  endtask

  // Final accept happened at the previous edge: DRAIN edge next, then done.
  task automatic finish_run(input string tag);
    @(posedge clk); #1;
    check({tag, ".busy_after_drain"}, 32'(busy), 32'd0);
    check({tag, ".done_early"},       32'(done), 32'd0);
    @(posedge clk); #1;
    check({tag, ".done_latency"},     32'(done), 32'd1);
  endtask

  task automatic random_vld(input int n, input string tag,
                            input int exp_vcnt, input int exp_err, input bit exp_seq, input bit exp_done);
    for (int k = 0; k < n; k++) begin
      a    = 4'($urandom_range(15));
      b    = 4'($urandom_range(15));
      cin  = 1'($urandom_range(1));
      s    = 4'($urandom_range(15));
      cout = 1'($urandom_range(1));
      vld  = 1'b1;
      @(posedge clk); #1;
    end
    vld = 1'b0;
    check({tag, ".vec_cnt"}, 32'(vec_cnt), exp_vcnt);
    check({tag, ".err_cnt"}, 32'(err_cnt), exp_err);
    check({tag, ".seq_err"}, 32'(seq_err), 32'(exp_seq));
    check({tag, ".done"},    32'(done),    32'(exp_done));
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; vld = 1'b0;
    a = '0; b = '0; cin = 1'b0; s = '0; cout = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check_all_zero("reset");

    random_vld(6, "idle_immunity", 0, 0, 1'b0, 1'b0);

    // Correct adder, all 512 vectors back to back.
    push_exp("good", 0, 1'b0, 1'b1, 1'b0, 0, 0, 0, 0);
    pulse_start("good");
    run_vectors(M_GOOD, -1, 512, 1'b0);
    finish_run("good");

    random_vld(6, "done_immunity", 512, 0, 1'b0, 1'b1);
    check("done_immunity.pass", 32'(pass), 32'd1);

    // s forced to 0 on a=3,b=5,cin=0 only: observed {cout,s} = 0.
    push_exp("fault1", 1, 1'b0, 1'b0, 1'b1, 3, 5, 0, 0);
    pulse_start("fault1");
    run_vectors(M_FAULT1, -1, 512, 1'b0);
    finish_run("fault1");

    // cout stuck low: every vector with a+b+cin >= 16 fails.
    // cin=0 gives sum_{a=1..15} a = 120, cin=1 gives sum_{a=0..15} (a+1) = 136.
    // First in counting order is a=15,b=1,cin=0 with observed {0,4'h0}.
    push_exp("stuck", 256, 1'b0, 1'b0, 1'b1, 15, 1, 0, 0);
    pulse_start("stuck");
    run_vectors(M_STUCK, -1, 512, 1'b0);
    finish_run("stuck");

    // Index 7 skipped; arithmetic is still correct.
    push_exp("order", 0, 1'b1, 1'b0, 1'b0, 0, 0, 0, 0);
    pulse_start("order");
    run_vectors(M_GOOD, 7, 512, 1'b0);
    finish_run("order");

    // Gapped run interrupted by reset after 100 accepts.
    pulse_start("midrst");
    run_vectors(M_GOOD, -1, 100, 1'b1);
    check("midrst.vec_cnt_before", 32'(vec_cnt), 32'd100);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check_all_zero("midrst");

    push_exp("rerun", 0, 1'b0, 1'b1, 1'b0, 0, 0, 0, 0);
    pulse_start("rerun");
    run_vectors(M_GOOD, -1, 512, 1'b1);
    finish_run("rerun");

    repeat (3) @(posedge clk);
    #1;
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
